// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle logic/add/sub/compare/shift ops
// and a WIDTH-cycle shift-add unsigned multiplier. Flags are sticky: each op
// rewrites only the bits it owns.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       opcode,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] rout,
  output logic [7:0]       flag,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int SW = $clog2(WIDTH);
  localparam logic [CW-1:0] CLAST = CW'(WIDTH - 1);
  localparam logic [31:0]   WLIM  = WIDTH;

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_NOT  = 8'h04;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_RSH  = 8'h08;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_ALSH = 8'h0C;
  localparam logic [7:0] OP_MUL  = 8'h0E;
  localparam logic [7:0] OP_ARSH = 8'h0F;
  localparam logic [7:0] OP_LSH  = 8'h84;

  // flag bit positions
  localparam int FC = 0;
  localparam int FL = 2;
  localparam int FF = 5;
  localparam int FZ = 6;
  localparam int FN = 7;

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t state_q, state_d;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] ma_q, ma_d;      // multiplicand, shifted left each step
  logic [WIDTH-1:0]   mb_q, mb_d;      // multiplier, shifted right each step
  logic [2*WIDTH-1:0] acc_q, acc_d;    // partial product
  logic [2*WIDTH-1:0] acc_step;
  logic               mul_last;

  logic [WIDTH-1:0]   rout_d;
  logic [7:0]         flag_d;
  logic               done_d, illegal_d;

  logic               cin;
  logic [WIDTH:0]     sum, diff;
  logic               add_ovf, sub_ovf;
  logic               shamt_big;
  logic [SW-1:0]      shamt;
  logic [WIDTH-1:0]   lsh, rsh, arsh;

  // Z/N update helper shared by most ops
  function automatic logic [7:0] set_zn(input logic [7:0] f, input logic [WIDTH-1:0] v);
    logic [7:0] r;
    r     = f;
    r[FZ] = (v == '0);
    r[FN] = v[WIDTH-1];
    return r;
  endfunction

  assign busy = (state_q == MUL);

  // Adder/subtractor at WIDTH+1 bits so carry/borrow falls out of the top bit.
  // ADDC pulls in the stored carry; ADD/ADDU add zero.
  assign cin     = (opcode == OP_ADDC) ? flag[FC] : 1'b0;
  assign sum     = {1'b0, r1} + {1'b0, r2} + {{WIDTH{1'b0}}, cin};
  assign diff    = {1'b0, r1} - {1'b0, r2};
  assign add_ovf = (r1[WIDTH-1] == r2[WIDTH-1]) && (sum[WIDTH-1] != r1[WIDTH-1]);
  assign sub_ovf = (r1[WIDTH-1] != r2[WIDTH-1]) && (diff[WIDTH-1] != r1[WIDTH-1]);

  // Shift amount is the whole of r1; anything >= WIDTH saturates.
  assign shamt_big = (32'(r1) >= WLIM);
  assign shamt     = r1[SW-1:0];
  assign lsh       = shamt_big ? '0 : (r2 << shamt);
  assign rsh       = shamt_big ? '0 : (r2 >> shamt);
  assign arsh      = shamt_big ? {WIDTH{r2[WIDTH-1]}} : $unsigned($signed(r2) >>> shamt);

  // One shift-add step per MUL cycle
  assign acc_step = mb_q[0] ? (acc_q + ma_q) : acc_q;
  assign mul_last = (cnt_q == CLAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: only an accepted MUL leaves IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && opcode == OP_MUL) state_d = MUL;
      MUL:     if (mul_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: single-cycle ops resolve on the accept edge,
  // MUL writes its result on the edge that consumes the last multiplier bit.
  always_comb begin
    rout_d    = rout;
    flag_d    = flag;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    cnt_d     = cnt_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    acc_d     = acc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          done_d = 1'b1;
          case (opcode)
            OP_AND: begin rout_d = r1 & r2; flag_d = set_zn(flag, r1 & r2); end
            OP_OR:  begin rout_d = r1 | r2; flag_d = set_zn(flag, r1 | r2); end
            OP_XOR: begin rout_d = r1 ^ r2; flag_d = set_zn(flag, r1 ^ r2); end
            OP_NOT: begin rout_d = ~r1;     flag_d = set_zn(flag, ~r1);     end
            OP_ADD, OP_ADDC: begin
              rout_d     = sum[WIDTH-1:0];
              flag_d     = set_zn(flag, sum[WIDTH-1:0]);
              flag_d[FC] = sum[WIDTH];
              flag_d[FF] = add_ovf;
            end
            OP_ADDU: begin
              rout_d     = sum[WIDTH-1:0];
              flag_d[FC] = sum[WIDTH];
            end
            OP_SUB: begin
              rout_d     = diff[WIDTH-1:0];
              flag_d     = set_zn(flag, diff[WIDTH-1:0]);
              flag_d[FC] = diff[WIDTH];
              flag_d[FF] = sub_ovf;
            end
            OP_CMP: begin
              flag_d[FZ] = (r1 == r2);
              flag_d[FL] = (r1 < r2);
              flag_d[FN] = ($signed(r1) < $signed(r2));
            end
            OP_LSH, OP_ALSH: begin rout_d = lsh;  flag_d = set_zn(flag, lsh);  end
            OP_RSH:          begin rout_d = rsh;  flag_d = set_zn(flag, rsh);  end
            OP_ARSH:         begin rout_d = arsh; flag_d = set_zn(flag, arsh); end
            OP_MUL: begin
              done_d = 1'b0;
              ma_d   = {{WIDTH{1'b0}}, r1};
              mb_d   = r2;
              acc_d  = '0;
              cnt_d  = '0;
            end
            default: illegal_d = 1'b1;
          endcase
        end
      end
      MUL: begin
        acc_d = acc_step;
        ma_d  = ma_q << 1;
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (mul_last) begin
          rout_d     = acc_step[WIDTH-1:0];
          flag_d     = set_zn(flag, acc_step[WIDTH-1:0]);
          flag_d[FF] = |acc_step[2*WIDTH-1:WIDTH];
          done_d     = 1'b1;
          cnt_d      = '0;
        end
      end
      default: ;
    endcase
  end

  // Result, flags, pulses and multiplier datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rout    <= '0;
      flag    <= 8'h00;
      done    <= 1'b0;
      illegal <= 1'b0;
      cnt_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
    end else begin
      rout    <= rout_d;
      flag    <= flag_d;
      done    <= done_d;
      illegal <= illegal_d;
      cnt_q   <= cnt_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
    end
  end

endmodule
